// File: rtl/bus_pkg.sv
// Shared types for the serial slave port: FSM state encoding, mode values
// and a small elaboration-time helper.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_IN,
    DATA_IN,
    WRITE,
    WAIT,
    SPLIT,
    SEND
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial shift register with synchronous clear and parallel load;
// used for address capture, write-data capture and read-data serialisation.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // Pure datapath storage: no reset, the controlling FSM qualifies every use.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= WIDTH'({q, sin});
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/slave_port_v3.sv
// Serial bus slave with local memory: shifts in address/data MSB first,
// supports delayed reads with optional split release of the bus.
module slave_port_v3
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 64,
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 4,
  parameter int SPLIT_EN     = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  input  logic split_grant,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic split,
  output logic addr_err
);

  localparam int CNT_W = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, READ_LATENCY) + 1);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      LAT_LAST  = CNT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  // One extra bit keeps the borrow, so addresses below BASE land far above DEPTH.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (({1'b0, a} - {1'b0, BASE}) < DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a - BASE);
  endfunction

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic                    mode_q;
  logic                    addr_err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_full;
  logic                    addr_en, data_en, addr_last, data_last;
  logic                    send_acc, send_last, lat_done, capture, mode_eff;
  logic                    out_msb;
  logic                    unused_addr_msb, unused_data_msb;
  logic [DATA_WIDTH-1:0]   unused_out_q;

  assign addr_en   = master_valid && (state == ADDR_IN);
  assign data_en   = master_valid && (state == DATA_IN);
  assign addr_last = addr_en && (cnt == ADDR_LAST);
  assign data_last = data_en && (cnt == DATA_LAST);
  assign send_acc  = master_ready && (state == SEND);
  assign send_last = send_acc && (cnt == DATA_LAST);
  assign lat_done  = (cnt >= LAT_LAST);
  assign mode_eff  = (cnt == '0) ? mode : mode_q;
  assign addr_full = ADDR_WIDTH'({addr_q, wr_bus});
  assign capture   = ((state == WAIT) || (state == SPLIT)) && (state_n == SEND);
  assign rd_word   = in_range(addr_q) ? mem[mem_idx(addr_q)] : '0;

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk(clk), .clr(state == IDLE), .load(1'b0), .load_val('0),
    .en(addr_en), .sin(wr_bus), .q(addr_q), .sout(unused_addr_msb)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk(clk), .clr(state == IDLE), .load(1'b0), .load_val('0),
    .en(data_en), .sin(wr_bus), .q(data_q), .sout(unused_data_msb)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_out_sr (
    .clk(clk), .clr(1'b0), .load(capture), .load_val(rd_word),
    .en(send_acc), .sin(1'b0), .q(unused_out_q), .sout(out_msb)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (master_valid) state_n = ADDR_IN;
      ADDR_IN: begin
        if (!master_valid)            state_n = IDLE;
        else if (cnt == ADDR_LAST)    state_n = (mode_eff == MODE_WRITE) ? DATA_IN : WAIT;
      end
      DATA_IN: begin
        if (!master_valid)            state_n = IDLE;
        else if (cnt == DATA_LAST)    state_n = WRITE;
      end
      WRITE:   state_n = IDLE;
      WAIT: begin
        if (SPLIT_EN != 0)            state_n = SPLIT;
        else if (cnt == LAT_LAST)     state_n = SEND;
      end
      SPLIT:   if (lat_done && split_grant) state_n = SEND;
      SEND:    if (send_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= MODE_READ;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_n;
      addr_err_q <= addr_last && !in_range(addr_full);
      case (state)
        ADDR_IN: if (addr_en) begin
          if (cnt == '0) mode_q <= mode;
          cnt <= addr_last ? '0 : cnt + 1'b1;
        end
        DATA_IN: if (data_en) cnt <= data_last ? '0 : cnt + 1'b1;
        WAIT:    cnt <= (state_n == SEND) ? '0 : cnt + 1'b1;
        // Saturate once latency is met so a late grant never overflows the count.
        SPLIT: begin
          if (state_n == SEND) cnt <= '0;
          else if (!lat_done)  cnt <= cnt + 1'b1;
        end
        SEND:    if (send_acc) cnt <= send_last ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == WRITE) && in_range(addr_q)) begin
      mem[mem_idx(addr_q)] <= data_q;
    end
  end

  assign slave_ready = (state == ADDR_IN) || (state == DATA_IN);
  assign slave_valid = (state == SEND);
  assign split       = (state == SPLIT);
  assign addr_err    = addr_err_q;
  assign rd_bus      = (state == SEND) && out_msb;

endmodule
